// File: rtl/sn_mem.sv
// sn_mem: request-buffered word memory.
// Requests (read/write) are announced one cycle ahead, queued in a small FIFO
// and answered in order through a three-state tx sequencer
// (IDLE -> PRE -> ASSERT).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | no response in flight; waits for a queued entry and no stall
//   S_PRE    | pre_tx_data announced; next cycle is ASSERT regardless of stall
//   S_ASSERT | v_tx_data high, head entry popped; chains if more remain
module sn_mem #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pre_rx_req,
  input  logic                           v_rx_req,
  input  logic [1:0]                     rx_req_opcode,
  input  logic [ADDR_WIDTH-1:0]          rx_req_addr,
  input  logic [WORD_WIDTH-1:0]          rx_req_data,
  output logic                           rx_full,
  input  logic                           tx_stall,
  output logic                           pre_tx_data,
  output logic                           v_tx_data,
  output logic [1:0]                     tx_opcode,
  output logic [ADDR_WIDTH-1:0]          tx_addr,
  output logic [WORD_WIDTH-1:0]          tx_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] outstanding,
  output logic                           err_proto,
  output logic                           err_overflow
);

  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int MEM_WORDS = 1 << ADDR_WIDTH;

  localparam logic [1:0] OP_DATA_RECV = 2'b10;
  localparam logic [1:0] OP_COMP      = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRE    = 2'd1,
    S_ASSERT = 2'd2
  } tx_state_t;

  tx_state_t state, state_nxt;

  logic                  pre_q;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic                  fifo_wr   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] mem       [MEM_WORDS];

  logic                  req_legal, fifo_full, push, pop, more_after_pop;
  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WORD_WIDTH-1:0] head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A request is legal only if announced last cycle and it is a read or write.
  assign req_legal      = v_rx_req && pre_q && !rx_req_opcode[1];
  // Full means every entry is taken; a pop in the same cycle does not make room.
  assign fifo_full      = (count == CW'(FIFO_DEPTH));
  assign push           = req_legal && !fifo_full;
  assign pop            = (state == S_ASSERT);
  assign more_after_pop = (count > CW'(1)) || push;
  assign rx_full        = (count > CW'(FIFO_DEPTH - 2));
  assign outstanding    = count;

  assign head_wr   = fifo_wr[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Request intake: announce tracking, FIFO pointers/occupancy, error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q        <= 1'b0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      err_proto    <= 1'b0;
      err_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_wr[i]   <= 1'b0;
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      pre_q     <= pre_rx_req;
      err_proto <= v_rx_req && !req_legal;
      if (req_legal && fifo_full) err_overflow <= 1'b1;
      if (push) begin
        fifo_wr[wr_ptr]   <= rx_req_opcode[0];
        fifo_addr[wr_ptr] <= rx_req_addr;
        fifo_data[wr_ptr] <= rx_req_data;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Word storage: reset to its own index, written when a write head is answered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= WORD_WIDTH'(i);
    end else if (pop && head_wr) begin
      mem[head_addr] <= head_data;
    end
  end

  // Tx sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Tx sequencer next state; the incoming push counts so an empty-queue request
  // is announced the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (((count != '0) || push) && !tx_stall) state_nxt = S_PRE;
      S_PRE:    state_nxt = S_ASSERT;
      S_ASSERT: state_nxt = (more_after_pop && !tx_stall) ? S_ASSERT : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Tx outputs; response fields are held at zero outside the valid cycle.
  always_comb begin
    pre_tx_data = 1'b0;
    v_tx_data   = 1'b0;
    tx_opcode   = '0;
    tx_addr     = '0;
    tx_data     = '0;
    case (state)
      S_PRE: pre_tx_data = 1'b1;
      S_ASSERT: begin
        v_tx_data   = 1'b1;
        pre_tx_data = (state_nxt == S_ASSERT);
        tx_addr     = head_addr;
        if (head_wr) begin
          tx_opcode = OP_COMP;
          tx_data   = head_data;
        end else begin
          tx_opcode = OP_DATA_RECV;
          tx_data   = mem[head_addr];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sn_mem.sv
// tb_sn_mem: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a queue/array reference model.
module tb_sn_mem;
  localparam int WW = 8;
  localparam int AW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pre_rx_req = 1'b0;
  logic          v_rx_req = 1'b0;
  logic [1:0]    rx_req_opcode = '0;
  logic [AW-1:0] rx_req_addr = '0;
  logic [WW-1:0] rx_req_data = '0;
  logic          tx_stall = 1'b0;
  logic          rx_full, pre_tx_data, v_tx_data, err_proto, err_overflow;
  logic [1:0]    tx_opcode;
  logic [AW-1:0] tx_addr;
  logic [WW-1:0] tx_data;
  logic [$clog2(FD+1)-1:0] outstanding;

  logic rst_next = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sn_mem #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .pre_rx_req(pre_rx_req), .v_rx_req(v_rx_req),
    .rx_req_opcode(rx_req_opcode), .rx_req_addr(rx_req_addr),
    .rx_req_data(rx_req_data), .rx_full(rx_full), .tx_stall(tx_stall),
    .pre_tx_data(pre_tx_data), .v_tx_data(v_tx_data), .tx_opcode(tx_opcode),
    .tx_addr(tx_addr), .tx_data(tx_data), .outstanding(outstanding),
    .err_proto(err_proto), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs (and reset) change just after the rising edge, the
  // caller resumes at the falling edge where outputs are settled.
  task automatic step(input logic p, input logic v, input logic [1:0] op,
                      input logic [AW-1:0] a, input logic [WW-1:0] d, input logic st);
    @(posedge clk);
    #1;
    reset         = rst_next;
    pre_rx_req    = p;
    v_rx_req      = v;
    rx_req_opcode = op;
    rx_req_addr   = a;
    rx_req_data   = d;
    tx_stall      = st;
    @(negedge clk);
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 2'b00, '0, '0, st);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } req_t;

  req_t          q[$];
  logic [WW-1:0] m_mem [1<<AW];
  bit            m_prev_pre, m_announce, m_go, m_errp, m_erro;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = WW'(i);
    m_prev_pre = 0; m_announce = 0; m_go = 0; m_errp = 0; m_erro = 0;
  endtask

  // Every falling edge: compare all outputs with the model, then advance it.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs",
          {pre_tx_data, v_tx_data, tx_opcode, tx_addr, tx_data, outstanding,
           rx_full, err_proto, err_overflow}, '0);
      model_reset();
    end else begin
      bit   legal, acc, ovf, exp_v, exp_pre;
      int   after;
      req_t h;
      legal = v_rx_req && m_prev_pre && (rx_req_opcode < 2);
      acc   = legal && (q.size() < FD);
      ovf   = legal && (q.size() >= FD);
      exp_v = m_announce;
      chk("outstanding", 32'(outstanding), 32'(q.size()));
      chk("rx_full", 32'(rx_full), 32'(q.size() > FD - 2));
      chk("err_proto", 32'(err_proto), 32'(m_errp));
      chk("err_overflow", 32'(err_overflow), 32'(m_erro));
      if (exp_v && q.size() == 0) begin
        chk("model_underflow", 32'(q.size()), 32'd1);
        exp_v = 0;
      end
      after   = q.size() - (exp_v ? 1 : 0) + (acc ? 1 : 0);
      exp_pre = m_go || (exp_v && after > 0 && !tx_stall);
      chk("v_tx_data", 32'(v_tx_data), 32'(exp_v));
      chk("pre_tx_data", 32'(pre_tx_data), 32'(exp_pre));
      if (exp_v) begin
        h = q.pop_front();
        chk("tx_opcode", 32'(tx_opcode), h.wr ? 32'd3 : 32'd2);
        chk("tx_addr", 32'(tx_addr), 32'(h.addr));
        chk("tx_data", 32'(tx_data), h.wr ? 32'(h.data) : 32'(m_mem[h.addr]));
        if (h.wr) m_mem[h.addr] = h.data;
      end else begin
        chk("tx_idle_zero", {tx_opcode, tx_addr, tx_data}, '0);
      end
      if (acc) q.push_back('{wr: rx_req_opcode[0], addr: rx_req_addr, data: rx_req_data});
      m_go       = !exp_pre && !exp_v && (after > 0) && !tx_stall;
      m_announce = exp_pre;
      m_errp     = v_rx_req && !legal;
      m_erro     = m_erro || ovf;
      m_prev_pre = pre_rx_req;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    rst_next = 1'b0;
    idle(0); idle(0);
    chk("rst_pre", 32'(pre_tx_data), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    rst_next = 1'b1;

    // read addr 5 after reset: pre at T+1, valid at T+2 with data 5
    step(1, 0, 2'b00, 4'd0, 8'h00, 0);
    step(0, 1, 2'b00, 4'd5, 8'h00, 0);
    chk("rd5_T_pre", 32'(pre_tx_data), 0);
    idle(0);
    chk("rd5_T1_pre", 32'(pre_tx_data), 1);
    chk("rd5_T1_v", 32'(v_tx_data), 0);
    idle(0);
    chk("rd5_T2_v", 32'(v_tx_data), 1);
    chk("rd5_T2_op", 32'(tx_opcode), 32'h2);
    chk("rd5_T2_addr", 32'(tx_addr), 5);
    chk("rd5_T2_data", 32'(tx_data), 5);
    idle(0);
    chk("rd5_T3_v", 32'(v_tx_data), 0);

    // write 3 <= A5 then read 3
    step(1, 0, 2'b00, 4'd0, 8'h00, 0);
    step(1, 1, 2'b01, 4'd3, 8'hA5, 0);
    step(0, 1, 2'b00, 4'd3, 8'h00, 0);
    chk("wr3_pre", 32'(pre_tx_data), 1);
    idle(0);
    chk("wr3_op", 32'(tx_opcode), 32'h3);
    chk("wr3_data", 32'(tx_data), 32'hA5);
    chk("wr3_chain_pre", 32'(pre_tx_data), 1);
    idle(0);
    chk("rd3_op", 32'(tx_opcode), 32'h2);
    chk("rd3_data", 32'(tx_data), 32'hA5);
    idle(0); idle(0);

    // protocol errors: no announce, then illegal opcode
    step(0, 1, 2'b00, 4'd1, 8'h00, 0);
    idle(0);
    chk("proto_pulse", 32'(err_proto), 1);
    chk("proto_outstanding", 32'(outstanding), 0);
    idle(0);
    chk("proto_clear", 32'(err_proto), 0);
    chk("proto_no_resp", 32'(v_tx_data), 0);
    step(1, 0, 2'b00, 4'd0, 8'h00, 0);
    step(0, 1, 2'b11, 4'd2, 8'h00, 0);
    idle(0);
    chk("proto_comp", 32'(err_proto), 1);
    idle(0); idle(0);

    // four reads under stall, a fifth overflows, then release
    step(1, 0, 2'b00, 4'd0, 8'h00, 1);
    step(1, 1, 2'b00, 4'd8, 8'h00, 1);
    step(1, 1, 2'b00, 4'd9, 8'h00, 1);
    step(1, 1, 2'b00, 4'd10, 8'h00, 1);
    chk("full_at2", 32'(rx_full), 0);
    step(1, 1, 2'b00, 4'd11, 8'h00, 1);
    chk("full_at3", 32'(rx_full), 1);
    step(0, 1, 2'b00, 4'd12, 8'h00, 1);
    chk("occ4", 32'(outstanding), 4);
    idle(1);
    chk("ovf_set", 32'(err_overflow), 1);
    chk("ovf_occ", 32'(outstanding), 4);
    chk("stall_hold", 32'(pre_tx_data), 0);
    idle(0);
    idle(0);
    chk("rel_pre", 32'(pre_tx_data), 1);
    for (int k = 0; k < 4; k++) begin
      idle(0);
      chk("b2b_v", 32'(v_tx_data), 1);
      chk("b2b_addr", 32'(tx_addr), 32'(8 + k));
      chk("b2b_data", 32'(tx_data), 32'(8 + k));
    end
    idle(0);
    chk("b2b_end", 32'(v_tx_data), 0);
    chk("ovf_sticky", 32'(err_overflow), 1);

    // reset during PRE discards a pending write
    rst_next = 1'b0;
    idle(0);
    rst_next = 1'b1;
    idle(0);
    chk("ovf_cleared", 32'(err_overflow), 0);
    step(1, 0, 2'b00, 4'd0, 8'h00, 0);
    step(0, 1, 2'b01, 4'd3, 8'h5A, 0);
    rst_next = 1'b0;
    idle(0);
    chk("rstpre_pre", 32'(pre_tx_data), 0);
    chk("rstpre_occ", 32'(outstanding), 0);
    rst_next = 1'b1;
    idle(0);
    step(1, 0, 2'b00, 4'd0, 8'h00, 0);
    step(0, 1, 2'b00, 4'd3, 8'h00, 0);
    idle(0); idle(0);
    chk("rstpre_rd3_v", 32'(v_tx_data), 1);
    chk("rstpre_rd3_data", 32'(tx_data), 3);
    idle(0); idle(0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic p, v, st;
      logic [1:0] op;
      p  = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      st = ((i / 150) % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
      rst_next = ($urandom_range(0, 399) != 0);
      step(p, v, op, 4'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), st);
    end
    rst_next = 1'b1;
    idle(0); idle(0); idle(0); idle(0); idle(0); idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
